// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file / write-back scoreboard slice.
package reg_file_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) r++;
      return r;
   endfunction

   localparam int unsigned AW       = clog2(16);
   localparam int unsigned CNT_W    = clog2(3 + 1);
   localparam int unsigned PC_REG   = 15;

   typedef logic [AW-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      CNT_HOLD,
      CNT_INC,
      CNT_DEC,
      CNT_CLR
   } cnt_op_e;

endpackage

// File: rtl/reg_file_sb_if.sv
// ID-stage register file bus: read ports, issue tracking and write-back.
interface reg_file_sb_if #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned NUM_RD   = 2
);
   localparam int unsigned AW = reg_file_pkg::clog2(NUM_REGS);

   logic [NUM_RD*AW-1:0]     rd_addr;
   logic [NUM_RD-1:0]        rd_use;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        hazard;
   logic                     issue_en;
   logic [AW-1:0]            issue_dest;
   logic                     freeze;
   logic                     flush;
   logic                     wb_en;
   logic [AW-1:0]            wb_dest;
   logic [DATA_W-1:0]        wb_data;
   logic [NUM_REGS-1:0]      busy_mask;
   logic                     sb_err;

   modport master (
      output rd_addr, rd_use, issue_en, issue_dest, freeze, flush,
             wb_en, wb_dest, wb_data,
      input  rd_data, hazard, busy_mask, sb_err
   );

   modport slave (
      input  rd_addr, rd_use, issue_en, issue_dest, freeze, flush,
             wb_en, wb_dest, wb_data,
      output rd_data, hazard, busy_mask, sb_err
   );
endinterface

// File: rtl/reg_file_sb_counter.sv
// Saturating pending-write counter for one register; err flags an over/underflow attempt.
module sb_counter
   import reg_file_pkg::*;
#(
   parameter int unsigned MAX_PEND = 3,
   parameter int unsigned CNT_W    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             err_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   cnt_op_e          op;
   logic             err;

   // Flush wins over everything, including that cycle's write-back decrement.
   always_comb begin
      op = CNT_HOLD;
      if (clr_i)                op = CNT_CLR;
      else if (inc_i && !dec_i) op = CNT_INC;
      else if (dec_i && !inc_i) op = CNT_DEC;
   end

   always_comb begin
      cnt_d = cnt_q;
      err   = 1'b0;
      case (op)
         CNT_CLR: cnt_d = '0;
         CNT_INC: begin
            if (cnt_q == CNT_W'(MAX_PEND)) err = 1'b1;
            else                           cnt_d = cnt_q + CNT_W'(1);
         end
         CNT_DEC: begin
            if (cnt_q == '0) err = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign err_o = err;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with integrated write-back scoreboard for the ID stage.
// Optional WB_BYPASS_EN: write-through of same-cycle write-back data and hazard masking.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned MAX_PEND = 3
) (
   input  logic         clk,
   input  logic         rst,
   reg_file_sb_if.slave bus
);
   localparam int unsigned RAW   = clog2(NUM_REGS);
   localparam int unsigned RCW   = clog2(MAX_PEND + 1);

   logic [DATA_W-1:0]        regs_q [NUM_REGS];
   logic [RCW-1:0]           pend   [NUM_REGS];
   logic [NUM_REGS-1:0]      inc_v, dec_v, err_v, busy_c;
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        hazard_c;
   logic                     iss;
   logic                     sb_err_q, sb_err_d;

   assign iss = bus.issue_en && !bus.freeze && !bus.flush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      end else if (bus.wb_en) begin
         regs_q[bus.wb_dest] <= bus.wb_data;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
      assign inc_v[g]  = iss && (bus.issue_dest == RAW'(g));
      assign dec_v[g]  = bus.wb_en && (bus.wb_dest == RAW'(g));
      assign busy_c[g] = (pend[g] != '0);

      sb_counter #(
         .MAX_PEND (MAX_PEND),
         .CNT_W    (RCW)
      ) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .clr_i (bus.flush),
         .inc_i (inc_v[g]),
         .dec_i (dec_v[g]),
         .cnt_o (pend[g]),
         .err_o (err_v[g])
      );
   end

   assign sb_err_d = sb_err_q || (|err_v);

   always_ff @(posedge clk) begin
      if (!rst) sb_err_q <= 1'b0;
      else      sb_err_q <= sb_err_d;
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [RAW-1:0] a;
      logic           pend_nz;
      assign a       = bus.rd_addr[i*RAW +: RAW];
      assign pend_nz = (pend[a] != '0);
`ifdef WB_BYPASS_EN
      // The last owed write landing this cycle resolves the hazard through the forward path.
      logic wb_hit;
      assign wb_hit = bus.wb_en && (bus.wb_dest == a);
      assign rd_data_c[i*DATA_W +: DATA_W] = wb_hit ? bus.wb_data : regs_q[a];
      assign hazard_c[i] = bus.rd_use[i] && pend_nz &&
                           !(wb_hit && (pend[a] == RCW'(1)));
`else
      assign rd_data_c[i*DATA_W +: DATA_W] = regs_q[a];
      assign hazard_c[i] = bus.rd_use[i] && pend_nz;
`endif
   end

   assign bus.rd_data   = rd_data_c;
   assign bus.hazard    = hazard_c;
   assign bus.busy_mask = busy_c;
   assign bus.sb_err    = sb_err_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic vs. an array model.
module tb_reg_file_sb;
   import reg_file_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [31:0] m_regs [16];
   int          m_pend [16];
   bit          m_err;

   reg_file_sb_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(2)) bus ();

   reg_file_sb #(
      .DATA_W   (32),
      .NUM_REGS (16),
      .NUM_RD   (2),
      .MAX_PEND (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_rd(input int i);
      logic [3:0] a;
      a = bus.rd_addr[i*4 +: 4];
`ifdef WB_BYPASS_EN
      if (bus.wb_en && bus.wb_dest == a) return bus.wb_data;
`endif
      return m_regs[a];
   endfunction

   function automatic logic [1:0] exp_hz();
      logic [1:0] h;
      logic [3:0] a;
      for (int i = 0; i < 2; i++) begin
         a = bus.rd_addr[i*4 +: 4];
         h[i] = bus.rd_use[i] && (m_pend[a] != 0);
`ifdef WB_BYPASS_EN
         if (m_pend[a] == 1 && bus.wb_en && bus.wb_dest == a) h[i] = 1'b0;
`endif
      end
      return h;
   endfunction

   function automatic logic [15:0] exp_busy();
      logic [15:0] b;
      for (int r = 0; r < 16; r++) b[r] = (m_pend[r] != 0);
      return b;
   endfunction

   function automatic void model_edge();
      bit inc, dec;
      if (!rst) begin
         for (int r = 0; r < 16; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
         end
         m_err = 1'b0;
      end else begin
         if (bus.wb_en) m_regs[bus.wb_dest] = bus.wb_data;
         if (bus.flush) begin
            for (int r = 0; r < 16; r++) m_pend[r] = 0;
         end else begin
            for (int r = 0; r < 16; r++) begin
               inc = bus.issue_en && !bus.freeze && (bus.issue_dest == r);
               dec = bus.wb_en && (bus.wb_dest == r);
               if (inc && !dec) begin
                  if (m_pend[r] == 3) m_err = 1'b1;
                  else                m_pend[r]++;
               end else if (dec && !inc) begin
                  if (m_pend[r] == 0) m_err = 1'b1;
                  else                m_pend[r]--;
               end
            end
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      rst            = 1'b1;
      bus.rd_addr    = '0;
      bus.rd_use     = '0;
      bus.issue_en   = 1'b0;
      bus.issue_dest = '0;
      bus.freeze     = 1'b0;
      bus.flush      = 1'b0;
      bus.wb_en      = 1'b0;
      bus.wb_dest    = '0;
      bus.wb_data    = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic issue(input int r);
      idle();
      bus.issue_en   = 1'b1;
      bus.issue_dest = 4'(r);
      tick();
   endtask

   task automatic wb(input int r, input logic [31:0] d);
      idle();
      bus.wb_en   = 1'b1;
      bus.wb_dest = 4'(r);
      bus.wb_data = d;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      for (int r = 0; r < 4; r++) begin
         idle();
         bus.wb_en      = 1'b1;
         bus.wb_dest    = 4'(r);
         bus.wb_data    = $urandom | 32'h1;
         bus.issue_en   = 1'b1;
         bus.issue_dest = 4'(r + 8);
         tick();
      end
      idle();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      for (int r = 0; r < 8; r++) begin
         bus.rd_addr = {4'(r + 8), 4'(r)};
         #1;
         checks++;
         if (bus.rd_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_rd r%0d got %h exp 0", r, bus.rd_data);
         end
      end
      checks++;
      if (bus.busy_mask !== 16'h0) begin
         errors++;
         $display("FAIL reset_busy got %h exp 0", bus.busy_mask);
      end
      checks++;
      if (bus.sb_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err got %b exp 0", bus.sb_err);
      end
   endtask

   task automatic test_read_after_write();
      do_reset();
      wb(3, 32'hDEADBEEF);
      idle();
      bus.rd_addr = {4'd3, 4'd0};
      bus.rd_use  = 2'b10;
      #1;
      checks++;
      if (bus.rd_data[63:32] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL raw_data got %h exp deadbeef", bus.rd_data[63:32]);
      end
      checks++;
      if (bus.hazard !== 2'b00) begin
         errors++;
         $display("FAIL raw_hazard got %b exp 00", bus.hazard);
      end
   endtask

   task automatic test_raw_hazard();
      do_reset();
      issue(5);
      idle();
      bus.rd_addr = {4'd5, 4'd5};
      bus.rd_use  = 2'b01;
      #1;
      checks++;
      if (bus.hazard !== 2'b01) begin
         errors++;
         $display("FAIL hz_pending got %b exp 01", bus.hazard);
      end
      tick();
      checks++;
      if (bus.hazard !== 2'b01) begin
         errors++;
         $display("FAIL hz_hold got %b exp 01", bus.hazard);
      end
      bus.wb_en   = 1'b1;
      bus.wb_dest = 4'd5;
      bus.wb_data = 32'h12345678;
      #1;
`ifdef WB_BYPASS_EN
      checks++;
      if (bus.hazard !== 2'b00) begin
         errors++;
         $display("FAIL hz_wb_cycle got %b exp 00", bus.hazard);
      end
      checks++;
      if (bus.rd_data[31:0] !== 32'h12345678) begin
         errors++;
         $display("FAIL fwd_data got %h exp 12345678", bus.rd_data[31:0]);
      end
`else
      checks++;
      if (bus.hazard !== 2'b01) begin
         errors++;
         $display("FAIL hz_wb_cycle got %b exp 01", bus.hazard);
      end
      checks++;
      if (bus.rd_data[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL old_data got %h exp 0", bus.rd_data[31:0]);
      end
`endif
      tick();
      bus.wb_en = 1'b0;
      #1;
      checks++;
      if (bus.hazard !== 2'b00 || bus.rd_data[31:0] !== 32'h12345678) begin
         errors++;
         $display("FAIL hz_after_wb got hz %b data %h exp 00 12345678",
                  bus.hazard, bus.rd_data[31:0]);
      end
   endtask

   task automatic test_multi_pending();
      do_reset();
      for (int k = 0; k < 3; k++) issue(2);
      wb(2, 32'hA1);
      #1;
      checks++;
      if (bus.busy_mask[2] !== 1'b1) begin
         errors++;
         $display("FAIL mp_after1 got %b exp 1", bus.busy_mask[2]);
      end
      wb(2, 32'hA2);
      checks++;
      if (bus.busy_mask[2] !== 1'b1) begin
         errors++;
         $display("FAIL mp_after2 got %b exp 1", bus.busy_mask[2]);
      end
      wb(2, 32'hA3);
      bus.rd_addr = {4'd0, 4'd2};
      #1;
      checks++;
      if (bus.busy_mask[2] !== 1'b0 || bus.sb_err !== 1'b0 || bus.rd_data[31:0] !== 32'hA3) begin
         errors++;
         $display("FAIL mp_after3 got busy %b err %b data %h exp 0 0 a3",
                  bus.busy_mask[2], bus.sb_err, bus.rd_data[31:0]);
      end
      do_reset();
      for (int k = 0; k < 4; k++) issue(2);
      idle();
      #1;
      checks++;
      if (bus.sb_err !== 1'b1 || bus.busy_mask !== 16'h0004) begin
         errors++;
         $display("FAIL mp_overflow got err %b busy %h exp 1 0004", bus.sb_err, bus.busy_mask);
      end
   endtask

   task automatic test_gated_issue_flush();
      do_reset();
      idle();
      bus.issue_en   = 1'b1;
      bus.issue_dest = 4'd7;
      bus.freeze     = 1'b1;
      tick();
      idle();
      #1;
      checks++;
      if (bus.busy_mask[7] !== 1'b0) begin
         errors++;
         $display("FAIL freeze_issue got %b exp 0", bus.busy_mask[7]);
      end
      issue(7);
      issue(8);
      idle();
      bus.rd_addr = {4'd8, 4'd7};
      bus.rd_use  = 2'b11;
      #1;
      checks++;
      if (bus.hazard !== 2'b11 || bus.busy_mask !== 16'h0180) begin
         errors++;
         $display("FAIL pre_flush got hz %b busy %h exp 11 0180", bus.hazard, bus.busy_mask);
      end
      bus.flush      = 1'b1;
      bus.issue_en   = 1'b1;
      bus.issue_dest = 4'd9;
      tick();
      bus.flush    = 1'b0;
      bus.issue_en = 1'b0;
      #1;
      checks++;
      if (bus.hazard !== 2'b00 || bus.busy_mask !== 16'h0) begin
         errors++;
         $display("FAIL post_flush got hz %b busy %h exp 00 0000", bus.hazard, bus.busy_mask);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      issue(4);
      idle();
      bus.issue_en   = 1'b1;
      bus.issue_dest = 4'd4;
      bus.wb_en      = 1'b1;
      bus.wb_dest    = 4'd4;
      bus.wb_data    = 32'hCAFE0004;
      tick();
      idle();
      bus.rd_addr = {4'd9, 4'd4};
      #1;
      checks++;
      if (bus.busy_mask !== 16'h0010 || bus.rd_data[31:0] !== 32'hCAFE0004 || bus.sb_err !== 1'b0) begin
         errors++;
         $display("FAIL iss_wb_same got busy %h data %h err %b exp 0010 cafe0004 0",
                  bus.busy_mask, bus.rd_data[31:0], bus.sb_err);
      end
      wb(9, 32'hBEEF0009);
      bus.rd_addr = {4'd9, 4'd4};
      #1;
      checks++;
      if (bus.sb_err !== 1'b1 || bus.rd_data[63:32] !== 32'hBEEF0009) begin
         errors++;
         $display("FAIL underflow got err %b data %h exp 1 beef0009", bus.sb_err, bus.rd_data[63:32]);
      end
      do_reset();
      issue(6);
      idle();
      bus.flush   = 1'b1;
      bus.wb_en   = 1'b1;
      bus.wb_dest = 4'd6;
      bus.wb_data = 32'h66666666;
      tick();
      idle();
      bus.rd_addr = {4'd0, 4'd6};
      #1;
      checks++;
      if (bus.busy_mask !== 16'h0 || bus.sb_err !== 1'b0 || bus.rd_data[31:0] !== 32'h66666666) begin
         errors++;
         $display("FAIL flush_wb got busy %h err %b data %h exp 0000 0 66666666",
                  bus.busy_mask, bus.sb_err, bus.rd_data[31:0]);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst            = ($urandom_range(0, 59) != 0);
         bus.rd_addr    = 8'($urandom);
         bus.rd_use     = 2'($urandom);
         bus.issue_en   = ($urandom_range(0, 1) == 1);
         bus.issue_dest = 4'($urandom_range(0, 7));
         bus.freeze     = ($urandom_range(0, 3) == 0);
         bus.flush      = ($urandom_range(0, 15) == 0);
         bus.wb_en      = ($urandom_range(0, 1) == 1);
         bus.wb_dest    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
         bus.wb_data    = $urandom;
         if ($urandom_range(0, 1) == 1) bus.rd_addr[3:0] = bus.wb_dest;
         #1;
         checks++;
         if (bus.rd_data !== {exp_rd(1), exp_rd(0)}) begin
            errors++;
            $display("FAIL rnd_rd cyc %0d got %h exp %h", c, bus.rd_data, {exp_rd(1), exp_rd(0)});
         end
         checks++;
         if (bus.hazard !== exp_hz()) begin
            errors++;
            $display("FAIL rnd_hazard cyc %0d got %b exp %b", c, bus.hazard, exp_hz());
         end
         checks++;
         if (bus.busy_mask !== exp_busy()) begin
            errors++;
            $display("FAIL rnd_busy cyc %0d got %h exp %h", c, bus.busy_mask, exp_busy());
         end
         checks++;
         if (bus.sb_err !== m_err) begin
            errors++;
            $display("FAIL rnd_err cyc %0d got %b exp %b", c, bus.sb_err, m_err);
         end
         tick();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle();
      #2;
      test_reset();
      test_read_after_write();
      test_raw_hazard();
      test_multi_pending();
      test_gated_issue_flush();
      test_simultaneous();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
